rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with LSU winning.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 alu_valid  input  1  ALU writeback request.
REQ-005 alu_dest  input  3  ALU destination register index.
REQ-006 alu_data  input  16  ALU result.
REQ-007 alu_ready  output  1  ALU request granted this cycle.
REQ-008 lsu_valid  input  1  load writeback request.
REQ-009 lsu_dest  input  3  load destination register index.
REQ-010 lsu_data  input  16  load data.
REQ-011 lsu_ready  output  1  LSU request granted this cycle.
REQ-012 issue_en  input  1  decode issues an instruction that writes a GPR.
REQ-013 issue_dest  input  3  destination index of the issued instruction.
REQ-014 reg_write_en  output  1  GPR write-port enable, registered.
REQ-015 reg_write_dest  output  3  GPR write-port address, registered.
REQ-016 reg_write_data  output  16  GPR write-port data, registered.
REQ-017 busy  output  8  scoreboard; bit n = write to register n pending.

Function
REQ-018 A transfer occurs on a cycle where x_valid && x_ready; the handshake rules are as follows.
- x_ready is combinational from valid inputs and grant state.
- No ready is given to a non-valid requester.
REQ-019 Grant is given to at most one requester per cycle.
REQ-020 With only one requester valid, that requester is granted that same cycle.
REQ-021 Both valid and RR_EN=0: the LSU is granted.
REQ-022 Both valid and RR_EN=1: the grant goes to the requester that did not win the most recent contested cycle.
- The last-winner flag is updated only on contested cycles.
- The flag resets to "ALU last", so the LSU wins the first contest.
REQ-023 The losing requester holds valid, dest and data stable until granted; the block does not buffer losers.
REQ-024 Latency: the cycle after a transfer, reg_write_en=1 with the transferred dest and data.
- The GPR write then commits at that cycle's posedge.
REQ-025 reg_write_en=0 in any cycle following a cycle with no transfer.
- reg_write_dest and reg_write_data hold their last values when reg_write_en=0.
REQ-026 Back-to-back transfers on consecutive cycles produce consecutive reg_write_en pulses; throughput is one write per cycle.
REQ-027 issue_en sets busy[issue_dest] at posedge.
REQ-028 reg_write_en clears busy[reg_write_dest] at posedge.
REQ-029 Simultaneous set and clear of the same index: the set wins and the bit stays 1.
REQ-030 Setting an already-set bit leaves it at 1; the scoreboard keeps no count.
REQ-031 Simultaneous set and clear of different indices: both take effect.
REQ-032 ALU and LSU targeting the same dest while both valid are serialized in grant order; the later write overwrites the earlier.
REQ-033 All 8 registers, including index 0, are writable and tracked; there are no special cases.

Reset
REQ-034 rst_n low asynchronously forces the following, regardless of clk:
- reg_write_en=0, reg_write_dest=0, reg_write_data=0.
- busy=8'h00.
- last-winner flag = ALU.
REQ-035 While rst_n is low, alu_ready=0 and lsu_ready=0.
REQ-036 A transfer in flight when reset asserts is discarded; no write is emitted after reset.
REQ-037 After release, the first transfer can occur on the first posedge with rst_n high.

Verification
REQ-038 Reset check: hold rst_n=0 mid-stream with alu_valid=1 -> reg_write_en=0, busy=0, alu_ready=0, immediately and without waiting for a clk edge.
REQ-039 Single ALU write: alu_valid=1, dest=3, data=16'hBEEF for one cycle -> alu_ready=1 that cycle; next cycle reg_write_en=1, dest=3, data=16'hBEEF; the following cycle reg_write_en=0.
REQ-040 Contention with RR_EN=1: both valid continuously, ALU dest=1/data=16'h0001, LSU dest=2/data=16'h0002 -> grants alternate LSU, ALU, LSU; writes appear to regs 2, 1, 2 on consecutive cycles.
REQ-041 Contention with RR_EN=0: both valid for 3 cycles -> LSU granted all 3 cycles; ALU stalls with alu_ready=0 throughout.
REQ-042 Scoreboard: issue_en dest=5, then an LSU write to 5 -> busy=8'h20 until the write cycle, then 8'h00.
- Repeat with issue_en dest=5 in the same cycle as reg_write_en dest=5 -> busy stays 8'h20.
REQ-043 Same-dest race: ALU and LSU both target reg 4 with data 16'h1111 and 16'h2222, RR_EN=1 from reset -> write 16'h2222 then 16'h1111; final value is 16'h1111.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter (ALU vs LSU) onto one GPR write port plus a pending-write scoreboard.
// Latency 1 cycle to the write port; the loser is stalled via ready=0 and must hold its request.
module rf_wb_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [2:0]  alu_dest,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [2:0]  lsu_dest,
    input  logic [15:0] lsu_data,
    output logic        lsu_ready,
    input  logic        issue_en,
    input  logic [2:0]  issue_dest,
    output logic        reg_write_en,
    output logic [2:0]  reg_write_dest,
    output logic [15:0] reg_write_data,
    output logic [7:0]  busy
);

    localparam bit RR = (RR_EN != 0);

    logic       last_alu;
    logic       contested;
    logic       alu_xfer;
    logic       lsu_xfer;
    logic [7:0] busy_nxt;

    assign contested = alu_valid && lsu_valid;

    // Under contention the ALU only wins in round-robin mode when the LSU took the previous contest.
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (rst_n) begin
            if (contested) begin
                alu_ready = RR && !last_alu;
                lsu_ready = !(RR && !last_alu);
            end else begin
                alu_ready = alu_valid;
                lsu_ready = lsu_valid;
            end
        end
    end

    assign alu_xfer = alu_valid && alu_ready;
    assign lsu_xfer = lsu_valid && lsu_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_alu <= 1'b1;
        end else if (contested) begin
            last_alu <= alu_xfer;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= 3'd0;
            reg_write_data <= 16'd0;
        end else begin
            reg_write_en <= alu_xfer || lsu_xfer;
            if (lsu_xfer) begin
                reg_write_dest <= lsu_dest;
                reg_write_data <= lsu_data;
            end else if (alu_xfer) begin
                reg_write_dest <= alu_dest;
                reg_write_data <= alu_data;
            end
        end
    end

    // Clear first, then set, so a same-index set/clear leaves the bit pending.
    always_comb begin
        busy_nxt = busy;
        if (reg_write_en) begin
            busy_nxt[reg_write_dest] = 1'b0;
        end
        if (issue_en) begin
            busy_nxt[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 8'h00;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench: round-robin instance (dut) and fixed-priority instance (dut0) share stimulus.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lsu_valid, issue_en;
    logic [2:0]  alu_dest, lsu_dest, issue_dest;
    logic [15:0] alu_data, lsu_data;

    logic        alu_ready, lsu_ready, reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [7:0]  busy;

    logic        alu_ready0, lsu_ready0, reg_write_en0;
    logic [2:0]  reg_write_dest0;
    logic [15:0] reg_write_data0;
    logic [7:0]  busy0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_dest(lsu_dest), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .busy(busy)
    );

    rf_wb_arbiter #(.RR_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready0),
        .lsu_valid(lsu_valid), .lsu_dest(lsu_dest), .lsu_data(lsu_data), .lsu_ready(lsu_ready0),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .reg_write_en(reg_write_en0), .reg_write_dest(reg_write_dest0),
        .reg_write_data(reg_write_data0), .busy(busy0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_dest = 0; alu_data = 0;
        lsu_valid = 0; lsu_dest = 0; lsu_data = 0;
        issue_en = 0; issue_dest = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        alu_valid = 1; alu_dest = 3'd3; alu_data = 16'h0007;
        #2;
        total++; if (reg_write_en !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", reg_write_en); end
        total++; if (busy !== 8'h00) begin bad++; $display("FAIL rst_busy got=%h want=00", busy); end
        total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL rst_alu_ready got=%b want=0", alu_ready); end
        total++; if (reg_write_dest !== 3'd0 || reg_write_data !== 16'h0) begin
            bad++; $display("FAIL rst_wdat got=%0d/%h want=0/0000", reg_write_dest, reg_write_data); end
        tick();
        rst_n = 1;
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", alu_ready); end
        issue_en = 1; issue_dest = 3'd6;
        tick();
        total++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd3 || reg_write_data !== 16'h0007) begin
            bad++; $display("FAIL first_xfer got=%b/%0d/%h want=1/3/0007", reg_write_en, reg_write_dest, reg_write_data); end
        total++; if (busy !== 8'h40) begin bad++; $display("FAIL first_busy got=%h want=40", busy); end
        issue_en = 0;
        #2;
        rst_n = 0;
        #1;
        total++; if (reg_write_en !== 1'b0 || busy !== 8'h00 || alu_ready !== 1'b0) begin
            bad++; $display("FAIL midrst got=%b/%h/%b want=0/00/0", reg_write_en, busy, alu_ready); end
        alu_valid = 0;
        tick();
        rst_n = 1;
        tick();
        total++; if (reg_write_en !== 1'b0) begin bad++; $display("FAIL discard got=%b want=0", reg_write_en); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1; alu_dest = 3'd3; alu_data = 16'hBEEF;
        #1;
        total++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            bad++; $display("FAIL alu_grant got=%b/%b want=1/0", alu_ready, lsu_ready); end
        tick();
        alu_valid = 0; alu_data = 16'h0;
        total++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd3 || reg_write_data !== 16'hBEEF) begin
            bad++; $display("FAIL alu_write got=%b/%0d/%h want=1/3/beef", reg_write_en, reg_write_dest, reg_write_data); end
        tick();
        total++; if (reg_write_en !== 1'b0 || reg_write_dest !== 3'd3 || reg_write_data !== 16'hBEEF) begin
            bad++; $display("FAIL alu_hold got=%b/%0d/%h want=0/3/beef", reg_write_en, reg_write_dest, reg_write_data); end
    endtask

    task automatic test_single_lsu();
        lsu_valid = 1; lsu_dest = 3'd0; lsu_data = 16'h1234;
        #1;
        total++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
            bad++; $display("FAIL lsu_grant got=%b/%b want=1/0", lsu_ready, alu_ready); end
        tick();
        lsu_valid = 0;
        total++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd0 || reg_write_data !== 16'h1234) begin
            bad++; $display("FAIL lsu_write got=%b/%0d/%h want=1/0/1234", reg_write_en, reg_write_dest, reg_write_data); end
        tick();
    endtask

    task automatic test_rr_contention();
        logic [2:0] exp_lsu;
        logic [2:0] exp_dest;
        exp_lsu = 3'b101;
        exp_dest = 3'd0;
        alu_valid = 1; alu_dest = 3'd1; alu_data = 16'h0001;
        lsu_valid = 1; lsu_dest = 3'd2; lsu_data = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (lsu_ready !== exp_lsu[i] || alu_ready !== !exp_lsu[i]) begin
                bad++; $display("FAIL rr_grant%0d got lsu/alu=%b/%b want=%b/%b", i, lsu_ready, alu_ready, exp_lsu[i], !exp_lsu[i]); end
            tick();
            exp_dest = exp_lsu[i] ? 3'd2 : 3'd1;
            total++; if (reg_write_en !== 1'b1 || reg_write_dest !== exp_dest || reg_write_data !== {13'd0, exp_dest}) begin
                bad++; $display("FAIL rr_write%0d got=%b/%0d/%h want=1/%0d", i, reg_write_en, reg_write_dest, reg_write_data, exp_dest); end
        end
        idle_inputs();
        tick();
        total++; if (reg_write_en !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b want=0", reg_write_en); end
    endtask

    task automatic test_fixed_priority();
        alu_valid = 1; alu_dest = 3'd1; alu_data = 16'hAAAA;
        lsu_valid = 1; lsu_dest = 3'd2; lsu_data = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (lsu_ready0 !== 1'b1 || alu_ready0 !== 1'b0) begin
                bad++; $display("FAIL fp_grant%0d got lsu/alu=%b/%b want=1/0", i, lsu_ready0, alu_ready0); end
            tick();
            total++; if (reg_write_en0 !== 1'b1 || reg_write_dest0 !== 3'd2 || reg_write_data0 !== 16'h5555) begin
                bad++; $display("FAIL fp_write%0d got=%b/%0d/%h want=1/2/5555", i, reg_write_en0, reg_write_dest0, reg_write_data0); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        do_reset();
        issue_en = 1; issue_dest = 3'd5;
        tick();
        issue_en = 0;
        total++; if (busy !== 8'h20) begin bad++; $display("FAIL sb_set got=%h want=20", busy); end
        lsu_valid = 1; lsu_dest = 3'd5; lsu_data = 16'h00AA;
        tick();
        lsu_valid = 0;
        total++; if (busy !== 8'h20 || reg_write_en !== 1'b1) begin
            bad++; $display("FAIL sb_wcycle got=%h/%b want=20/1", busy, reg_write_en); end
        tick();
        total++; if (busy !== 8'h00) begin bad++; $display("FAIL sb_clear got=%h want=00", busy); end
        issue_en = 1; issue_dest = 3'd5;
        lsu_valid = 1; lsu_dest = 3'd5; lsu_data = 16'h00BB;
        tick();
        lsu_valid = 0;
        issue_en = 1; issue_dest = 3'd5;
        tick();
        issue_en = 0;
        total++; if (busy !== 8'h20) begin bad++; $display("FAIL sb_setwins got=%h want=20", busy); end
        lsu_valid = 1; lsu_dest = 3'd5; lsu_data = 16'h00CC;
        tick();
        lsu_valid = 0;
        issue_en = 1; issue_dest = 3'd2;
        tick();
        total++; if (busy !== 8'h04) begin bad++; $display("FAIL sb_diff got=%h want=04", busy); end
        issue_en = 1; issue_dest = 3'd2;
        tick();
        issue_en = 0;
        total++; if (busy !== 8'h04) begin bad++; $display("FAIL sb_reset got=%h want=04", busy); end
        alu_valid = 1; alu_dest = 3'd2; alu_data = 16'h0F0F;
        tick();
        alu_valid = 0;
        tick();
        total++; if (busy !== 8'h00) begin bad++; $display("FAIL sb_once got=%h want=00", busy); end
    endtask

    task automatic test_same_dest();
        do_reset();
        alu_valid = 1; alu_dest = 3'd4; alu_data = 16'h1111;
        lsu_valid = 1; lsu_dest = 3'd4; lsu_data = 16'h2222;
        tick();
        lsu_valid = 0;
        total++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd4 || reg_write_data !== 16'h2222) begin
            bad++; $display("FAIL race_first got=%b/%0d/%h want=1/4/2222", reg_write_en, reg_write_dest, reg_write_data); end
        tick();
        alu_valid = 0;
        total++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd4 || reg_write_data !== 16'h1111) begin
            bad++; $display("FAIL race_second got=%b/%0d/%h want=1/4/1111", reg_write_en, reg_write_dest, reg_write_data); end
        // The uncontested ALU grant must not have moved the last-winner flag off LSU.
        alu_valid = 1; alu_dest = 3'd7; alu_data = 16'h7777;
        lsu_valid = 1; lsu_dest = 3'd6; lsu_data = 16'h6666;
        #1;
        total++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            bad++; $display("FAIL flag_hold got alu/lsu=%b/%b want=1/0", alu_ready, lsu_ready); end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single_alu();
        test_single_lsu();
        test_rr_contention();
        test_fixed_priority();
        test_scoreboard();
        test_same_dest();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
